// File: rtl/seed_lfsr_stepper.sv
// Seed register that advances as a Fibonacci LFSR by a requested number of steps,
// with start/busy/done handshake, stall, zero-seed lockup guard and load-abort.
module seed_lfsr_stepper #(
  parameter int unsigned        WIDTH        = 64,
  parameter logic [WIDTH-1:0]   TAPS         = 64'hD800000000000000,
  parameter logic [WIDTH-1:0]   DEFAULT_SEED = 64'h1,
  parameter int unsigned        MAX_STEPS    = 255,
  localparam int unsigned       CW           = $clog2(MAX_STEPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CW-1:0]    nsteps,
  input  logic             stall,
  output logic [WIDTH-1:0] shift_seed,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;

  assign fb        = ^(seed_q & TAPS);
  assign step_val  = {seed_q[WIDTH-2:0], fb};
  assign load_zero = (seed == '0);
  // An all-zero seed would lock the LFSR, so substitute the default instead.
  assign load_val  = load_zero ? DEFAULT_SEED : seed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      seed_q   <= DEFAULT_SEED;
      count_q  <= '0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      count_q  <= count_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    count_d  = count_q;
    done_d   = 1'b0;
    lockup_d = lockup_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          seed_d   = load_val;
          lockup_d = load_zero;
        end else if (start) begin
          if (nsteps == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = nsteps;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (load) begin
          // Abort: the request is dropped silently, without a done pulse.
          seed_d   = load_val;
          lockup_d = load_zero;
          count_d  = '0;
          state_d  = StIdle;
        end else if (!stall) begin
          seed_d  = step_val;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_seed = seed_q;
    busy       = (state_q == StRun);
    done       = done_q;
    lockup     = lockup_q;
  end

endmodule

// File: tb/tb_seed_lfsr_stepper.sv
// Self-checking bench for seed_lfsr_stepper (8-bit, taps 8'hB8): directed vector table,
// a hand-written reset-mid-run sequence, and randomized traffic against a reference model.
module tb_seed_lfsr_stepper;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;
  localparam logic [7:0]  TP = 8'hB8;
  localparam logic [7:0]  DS = 8'h01;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed = '0;
  logic         start = 1'b0;
  logic [CW-1:0] nsteps = '0;
  logic         stall = 1'b0;
  logic [W-1:0] shift_seed;
  logic         busy, done, lockup;

  int errors = 0;
  int checks = 0;

  seed_lfsr_stepper #(
    .WIDTH       (W),
    .TAPS        (TP),
    .DEFAULT_SEED(DS),
    .MAX_STEPS   (255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .seed      (seed),
    .start     (start),
    .nsteps    (nsteps),
    .stall     (stall),
    .shift_seed(shift_seed),
    .busy      (busy),
    .done      (done),
    .lockup    (lockup)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] sd;
    logic       st;
    logic [7:0] n;
    logic       sl;
    logic [7:0] e_seed;
    logic       e_busy;
    logic       e_done;
    logic       e_lock;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic ld, input logic [7:0] sd, input logic st, input logic [7:0] n,
                     input logic sl, input logic [7:0] es, input logic eb, input logic ed,
                     input logic el);
    vec_t v;
    v.ld = ld; v.sd = sd; v.st = st; v.n = n; v.sl = sl;
    v.e_seed = es; v.e_busy = eb; v.e_done = ed; v.e_lock = el;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] es, input logic eb,
                           input logic ed, input logic el);
    check({tag, ".shift_seed"}, 64'(shift_seed), 64'(es));
    check({tag, ".busy"}, 64'(busy), 64'(eb));
    check({tag, ".done"}, 64'(done), 64'(ed));
    check({tag, ".lockup"}, 64'(lockup), 64'(el));
  endtask

  // Reference step from the feedback rule: parity of tapped bits shifted in at the LSB.
  function automatic logic [7:0] mstep(input logic [7:0] x);
    int ones;
    ones = $countones(x & TP);
    return {x[6:0], ones[0]};
  endfunction

  // Reference model state.
  logic [7:0] m_val;
  logic       m_lock;
  logic       m_run;
  logic       m_done;
  int         m_rem;

  task automatic model_edge(input logic ld, input logic [7:0] sd, input logic st,
                            input logic [7:0] n, input logic sl);
    m_done = 1'b0;
    if (ld) begin
      m_val  = (sd == 8'h00) ? DS : sd;
      m_lock = (sd == 8'h00);
      m_run  = 1'b0;
      m_rem  = 0;
    end else if (!m_run) begin
      if (st) begin
        if (n == 0) m_done = 1'b1;
        else begin
          m_rem = int'(n);
          m_run = 1'b1;
        end
      end
    end else if (!sl) begin
      m_val = mstep(m_val);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  initial begin
    // Directed table; each row is one cycle of inputs and the outputs after that edge.
    add(0, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0);
    add(0, 8'h00, 1, 4, 0, 8'h01, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h04, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h08, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h11, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 8'h11, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0);
    add(0, 8'h00, 1, 5, 0, 8'h01, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h04, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h08, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h11, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h23, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 8'h01, 0, 0, 1);
    add(1, 8'h5A, 0, 0, 0, 8'h5A, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h5A, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 8'h5A, 0, 0, 0);
    add(1, 8'h77, 1, 3, 0, 8'h77, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h77, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 8'h77, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'hEE, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 8'hEE, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'hDD, 0, 1, 0);
    add(0, 8'h00, 1, 5, 0, 8'hDD, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'hBB, 1, 0, 0);
    add(1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 8'h01, 0, 0, 1);
    add(0, 8'h00, 1, 2, 0, 8'h01, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 8'h04, 0, 1, 1);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h01, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("idle3", 8'h01, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      load = vt[i].ld; seed = vt[i].sd; start = vt[i].st; nsteps = vt[i].n; stall = vt[i].sl;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vt[i].e_seed, vt[i].e_busy, vt[i].e_done, vt[i].e_lock);
    end
    load = 0; start = 0; stall = 0;

    // Asynchronous reset in the middle of a run.
    load = 1; seed = 8'h5A;
    @(posedge clk);
    #1;
    load = 0; start = 1; nsteps = 8'd6;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    #3;
    check("midrun.busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_all("midrun_reset", 8'h01, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("after_reset", 8'h01, 0, 0, 0);

    // Randomized traffic against the reference model.
    m_val = DS; m_lock = 1'b0; m_run = 1'b0; m_done = 1'b0; m_rem = 0;
    for (int c = 0; c < 3000; c++) begin
      load   = ($urandom_range(0, 15) == 0);
      seed   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      start  = ($urandom_range(0, 2) == 0);
      nsteps = 8'($urandom_range(0, 12));
      stall  = ($urandom_range(0, 3) == 0);
      model_edge(load, seed, start, nsteps, stall);
      @(posedge clk);
      #1;
      check_all("rand", m_val, m_run, m_done, m_lock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seed_lfsr_stepper.md
Name: seed_lfsr_stepper

Overview:
- Parametrised successor to the plain seed register: holds a WIDTH-bit pattern seed and advances it as a Fibonacci LFSR by a requested number of steps.
- Supports start/busy/done handshake, stall, zero-seed lockup guard, and load-abort.
- Sits between the seed input logic and the pattern/display datapath, which consumes shift_seed.

Parameters:
- WIDTH, 64, register/LFSR width in bits (>=4).
- TAPS, 64'hD800000000000000, feedback mask; bit i set means bit i of the register feeds the XOR.
- DEFAULT_SEED, 64'h1, value after reset and substitute for an all-zero load; must be nonzero.
- MAX_STEPS, 255, largest step count per request.
- CW, $clog2(MAX_STEPS+1), width of nsteps; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  load seed this cycle.
- seed  input  WIDTH  value to load.
- start  input  1  request nsteps LFSR steps.
- nsteps  input  CW  step count, sampled with start.
- stall  input  1  freezes stepping while in RUN.
- shift_seed  output  WIDTH  current register value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a request completes.
- lockup  output  1  sticky flag: last load was all-zero.

Behaviour:
- Reset asserted (reset=0, asynchronous):
  - shift_seed=DEFAULT_SEED, state=IDLE, count=0, busy=0, done=0, lockup=0.
  - Deassertion is used synchronously by the surrounding logic.
- Step function: fb = ^(shift_seed & TAPS); next = {shift_seed[WIDTH-2:0], fb}.
- done defaults to 0 every cycle unless set below.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE:
  - load=1: shift_seed <= (seed==0 ? DEFAULT_SEED : seed); lockup <= (seed==0). load has priority over start in the same cycle, and that start is dropped.
  - start=1, nsteps==0: no shift; done=1 next cycle; stay IDLE.
  - start=1, nsteps=N>0: count <= N; state <= RUN.
- RUN:
  - load=1: abort. Apply the IDLE load rule, go to IDLE, no done pulse.
  - stall=1 and no load: hold shift_seed and count.
  - Otherwise: shift_seed <= next; count <= count-1. If count==1, go to IDLE and set done=1.
  - start is ignored while busy.
- Latency: start sampled at edge E0; shifts occur at E1..EN. After EN busy=0 and done=1 for exactly one cycle. Each stall cycle adds one cycle.
- A start in the same cycle done is high is accepted, since state is IDLE by then.
- lockup stays set until a load of a nonzero seed; steps do not clear it.
- nsteps values above MAX_STEPS are out of contract. The full CW-bit value is used, with no clamping.
- Reset mid-RUN: immediate return to the reset values; no done pulse.

Test Plan (WIDTH=8, TAPS=8'hB8, DEFAULT_SEED=8'h01):
- Release reset, idle 3 cycles -> shift_seed=8'h01, busy=0, done=0, lockup=0.
- load seed=8'h01, then start nsteps=4 -> shift_seed 02,04,08,11 on successive edges; busy high 4 cycles; done pulses once after the 8'h11 edge.
- start nsteps=5 from 8'h01 with stall=1 for 2 cycles after the 2nd step -> final value 8'h23; busy high 7 cycles; single done pulse.
- load seed=8'h00 -> shift_seed=8'h01, lockup=1. Then load seed=8'h5A -> shift_seed=8'h5A, lockup=0.
- start nsteps=0 -> shift_seed unchanged, busy stays 0, done=1 for 1 cycle. load and start in the same cycle -> seed loaded, no RUN.
- Mid-RUN load 8'h3C -> shift_seed=8'h3C, busy=0 next cycle, no done. Mid-RUN reset low -> shift_seed=8'h01 asynchronously, busy=0.
